stream_arbiter_mux: RTL and testbench
=====================================

STREAM_ARBITER_MUX -- requirements
Module: stream_arbiter_mux

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of input streams, range 1..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload bits per beat.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  NUM_PORTS  per-port beat valid.
REQ-006 SHALL have port in_ready  output  NUM_PORTS  per-port beat accepted.
REQ-007 SHALL have port in_data  input  NUM_PORTS x DATA_WIDTH  per-port payload.
REQ-008 SHALL have port in_last  input  NUM_PORTS  per-port final beat of packet.
REQ-009 SHALL have port out_valid  output  1  merged beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  merged payload.
REQ-012 SHALL have port out_last  output  1  merged final beat.
REQ-013 SHALL have port out_sel  output  SEL_WIDTH  index of routed port; SEL_WIDTH = max(1, clog2(NUM_PORTS)).

Function
REQ-014 SHALL implement two states: IDLE (no packet in flight) and LOCKED (packet in flight, owner held in register).
REQ-015 IDLE: grant SHALL be one-hot, chosen combinationally from in_valid per the priority of REQ-026/027; out_valid = OR of in_valid; out_data/out_last/out_sel from granted port; in_ready = grant AND out_ready.
REQ-016 LOCKED: only the owner SHALL be routed; out_valid = in_valid[owner]; in_ready[i] = 0 for all i != owner; other valids ignored.
REQ-017 IDLE -> LOCKED SHALL occur on a handshake (out_valid & out_ready) with out_last = 0; owner register loads the granted index.
REQ-018 IDLE stays IDLE on a handshake with out_last = 1 (single-beat packet); zero added latency.
REQ-019 LOCKED -> IDLE SHALL occur on a handshake with out_last = 1.
REQ-020 Path SHALL be combinational: zero-cycle latency from in_* to out_*; no buffering, no beat dropped or duplicated.
REQ-021 In IDLE with out_ready = 0, grant MAY change cycle to cycle; once a non-last beat is accepted, owner SHALL NOT change until its last beat is accepted.
REQ-022 out_data, out_last SHALL be zero when out_valid = 0; out_sel SHALL hold owner when LOCKED, else granted index, else 0.
REQ-023 NUM_PORTS = 1 SHALL degenerate to pass-through with out_sel = 0.

Reset
REQ-024 While rst = 1: state = IDLE, owner = 0, rotation pointer = 0; outputs then follow REQ-015 combinationally.
REQ-025 Reset asserted mid-packet SHALL abandon the packet; next cycle after release re-arbitrates from IDLE.

Configuration
REQ-026 Without ROUND_ROBIN_EN: fixed priority, lowest index wins.
REQ-027 With ROUND_ROBIN_EN defined: rotation pointer p (SEL_WIDTH bits); search starts at index p, wrapping; on each last-beat handshake p loads (winner + 1) mod NUM_PORTS.

Structure
REQ-028 Shared package SHALL hold the state enum (IDLE, LOCKED) and the SEL_WIDTH computation function.
REQ-029 Grant selection SHALL be one sub-module, priority_arbiter (lowest-set-bit one-hot); round-robin SHALL rotate request by p before and grant back after it.

Verification
REQ-030 Ports 0 and 2 valid, 3-beat packets, out_ready = 1, fixed priority -> port 0 packet fully out (out_sel = 0), then port 2 packet, no interleave.
REQ-031 LOCKED on port 1, port 0 raises valid mid-packet -> in_ready[0] = 0 until port 1 last beat accepted; port 0 granted next cycle.
REQ-032 out_ready toggling 1,0,1,0 during a 4-beat packet -> exactly 4 beats delivered in order, out_sel constant.
REQ-033 ROUND_ROBIN_EN, NUM_PORTS = 4, all valid, 1-beat packets -> out_sel sequence 0,1,2,3,0.
REQ-034 rst pulsed after beat 2 of a 4-beat port-3 packet, port 0 valid -> after release state IDLE, port 0 granted, out_sel = 0.

Source files
------------

// File: rtl/stream_arbiter_mux_pkg.sv
// Shared types for the packet-aware stream arbiter/mux: FSM state encoding and
// the select-width helper that keeps a 1-port build from collapsing to 0 bits.
package stream_arbiter_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_arbiter_mux_priority_arbiter.sv
// Lowest-index-wins one-hot grant; purely combinational.
module priority_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/stream_arbiter_mux.sv
// N-to-1 packet stream mux: arbitrates per packet, then holds the owner until its
// last beat. Define ROUND_ROBIN_EN for rotating priority (default: fixed, lowest wins).
module stream_arbiter_mux
  import stream_arbiter_mux_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int DATA_WIDTH = 32,
  localparam int SEL_WIDTH  = sel_width(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 in_valid,
  output logic [NUM_PORTS-1:0]                 in_ready,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic [SEL_WIDTH-1:0]                 out_sel
);

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   owner_q, owner_d;
  logic [NUM_PORTS-1:0]   req_arb, gnt_arb;
  logic [SEL_WIDTH-1:0]   gnt_pos, grant_idx, sel;
  logic                   hs;

`ifdef ROUND_ROBIN_EN
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;

  // Rotate requests so index ptr_q lands at position 0 of the fixed arbiter.
  always_comb begin
    req_arb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if ((i + int'(ptr_q)) % NUM_PORTS == j) req_arb[i] = in_valid[j];
      end
    end
  end
`else
  assign req_arb = in_valid;
`endif

  priority_arbiter #(.N(NUM_PORTS)) u_arb (
    .req_i (req_arb),
    .gnt_o (gnt_arb)
  );

  always_comb begin
    gnt_pos = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_arb[i]) gnt_pos = SEL_WIDTH'(i);
    end
`ifdef ROUND_ROBIN_EN
    grant_idx = SEL_WIDTH'((int'(gnt_pos) + int'(ptr_q)) % NUM_PORTS);
`else
    grant_idx = gnt_pos;
`endif
  end

  always_comb begin
    if (state_q == LOCKED) sel = owner_q;
    else if (|in_valid)    sel = grant_idx;
    else                   sel = '0;

    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (SEL_WIDTH'(i) == sel && in_valid[i]) begin
        out_valid   = 1'b1;
        out_data    = in_data[i];
        out_last    = in_last[i];
        in_ready[i] = out_ready;
      end
    end
    out_sel = sel;
  end

  assign hs = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (hs && !out_last) begin
          state_d = LOCKED;
          owner_d = sel;
        end
      end
      LOCKED: begin
        if (hs && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ROUND_ROBIN_EN
    ptr_d = ptr_q;
    if (hs && out_last) ptr_d = (sel == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : sel + SEL_WIDTH'(1);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_stream_arbiter_mux.sv
// Self-checking bench for stream_arbiter_mux (4 ports): directed packet scenarios
// followed by randomized traffic, all compared against a packet-level reference model.
module tb_stream_arbiter_mux;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SW = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         in_valid, in_ready, in_last;
  logic [N-1:0][DW-1:0] in_data;
  logic                 out_valid, out_ready, out_last;
  logic [DW-1:0]        out_data;
  logic [SW-1:0]        out_sel;

  always #5 clk = ~clk;

  stream_arbiter_mux #(.NUM_PORTS(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Source side: beats remaining in each port's current packet, beat counter, valid gaps.
  int rem[N];
  int seq[N];
  bit gap[N];
  bit auto_new = 0;

  // Reference model: is a packet in flight, who owns it, where the round-robin search starts.
  bit m_locked = 0;
  int m_owner  = 0;
  int m_ptr    = 0;

  int            hs_port[$];
  logic [DW-1:0] hs_data[$];

  function automatic logic [DW-1:0] beat(input int p, input int s);
    return DW'(p * 4096 + (s % 4096));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (rem[i] > 0) && !gap[i];
      in_data[i]  = beat(i, seq[i]);
      in_last[i]  = (rem[i] == 1);
    end
  endtask

  task automatic model_eval(output bit v, output int sel, output logic [DW-1:0] d,
                            output bit l, output logic [N-1:0] rdy);
    v   = 0;
    sel = 0;
    if (m_locked) begin
      sel = m_owner;
      v   = in_valid[m_owner];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (in_valid[(m_ptr + k) % N]) begin
          sel = (m_ptr + k) % N;
          v   = 1;
          break;
        end
      end
    end
    d   = v ? in_data[sel] : '0;
    l   = v ? in_last[sel] : 1'b0;
    rdy = '0;
    if (v) rdy[sel] = out_ready;
  endtask

  // Check all outputs mid-cycle, clock once, advance model and sources, drive next inputs.
  task automatic tick();
    bit            v, l;
    int            sel;
    logic [DW-1:0] d;
    logic [N-1:0]  rdy;
    #1;
    if (rst) begin
      m_locked = 0;
      m_owner  = 0;
      m_ptr    = 0;
    end
    model_eval(v, sel, d, l, rdy);
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_sel",   32'(out_sel),   sel);
    chk("out_data",  32'(out_data),  32'(d));
    chk("out_last",  32'(out_last),  32'(l));
    chk("in_ready",  32'(in_ready),  32'(rdy));
    @(posedge clk);
    if (!rst && v && out_ready) begin
      hs_port.push_back(sel);
      hs_data.push_back(d);
      if (!m_locked && !l) begin
        m_locked = 1;
        m_owner  = sel;
      end else if (m_locked && l) begin
        m_locked = 0;
      end
`ifdef ROUND_ROBIN_EN
      if (l) m_ptr = (sel + 1) % N;
`endif
      rem[sel]--;
      seq[sel]++;
    end
    @(negedge clk);
    if (auto_new) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
        gap[i] = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    drive_inputs();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      gap[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    clear_sources();
    drive_inputs();
    tick();
    tick();
    rst = 1'b0;
    drive_inputs();
  endtask

  task automatic run_until(input string tag, input int nbeats, input int maxc);
    int start = hs_port.size();
    for (int c = 0; c < maxc; c++) begin
      if (hs_port.size() - start >= nbeats) break;
      tick();
    end
    chk(tag, 32'(hs_port.size() - start >= nbeats), 32'd1);
  endtask

  initial begin
    int e030[6] = '{0, 0, 0, 2, 2, 2};
    int e031[4] = '{1, 1, 1, 0};
`ifdef ROUND_ROBIN_EN
    int e033[5] = '{0, 1, 2, 3, 0};
    int n033    = 5;
`else
    int e033[5] = '{0, 1, 2, 3, 0};
    int n033    = 4;
`endif
    int s0;

    for (int i = 0; i < N; i++) seq[i] = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    clear_sources();
    drive_inputs();
    #1;
    chk("rst_idle_valid", 32'(out_valid), 32'd0);
    chk("rst_idle_data",  32'(out_data),  32'd0);
    chk("rst_idle_sel",   32'(out_sel),   32'd0);
    chk("rst_idle_ready", 32'(in_ready),  32'd0);
    rem[2] = 1;
    drive_inputs();
    #1;
    chk("rst_comb_sel",   32'(out_sel),   32'd2);
    chk("rst_comb_valid", 32'(out_valid), 32'd1);
    chk("rst_comb_ready", 32'(in_ready),  32'b0100);
    rem[2] = 0;
    drive_inputs();
    tick();
    rst = 1'b0;
    drive_inputs();

    // Two competing 3-beat packets: no interleave.
    hs_port.delete();
    rem[0] = 3;
    rem[2] = 3;
    out_ready = 1'b1;
    drive_inputs();
    run_until("r030_timeout", 6, 20);
    for (int k = 0; k < 6; k++) chk($sformatf("r030_order%0d", k), hs_port[k], e030[k]);

    // Port 0 arrives while port 1 owns the output.
    hs_port.delete();
    rem[1] = 3;
    drive_inputs();
    tick();
    rem[0] = 1;
    drive_inputs();
    #1;
    chk("r031_blocked0", 32'(in_ready[0]), 32'd0);
    tick();
    run_until("r031_timeout", 2, 10);
    for (int k = 0; k < 4; k++) chk($sformatf("r031_order%0d", k), hs_port[k], e031[k]);

    // Backpressure toggling during a 4-beat packet.
    hs_port.delete();
    hs_data.delete();
    s0     = seq[2];
    rem[2] = 4;
    for (int c = 0; c < 20 && hs_port.size() < 4; c++) begin
      out_ready = (c % 2 == 0);
      drive_inputs();
      tick();
    end
    chk("r032_count", hs_port.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("r032_sel%0d", k),  hs_port[k], 2);
      chk($sformatf("r032_data%0d", k), 32'(hs_data[k]), 32'(beat(2, s0 + k)));
    end

    // All ports with single-beat packets.
    do_reset();
    hs_port.delete();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 1;
    drive_inputs();
    for (int c = 0; c < 20 && hs_port.size() < n033; c++) begin
`ifdef ROUND_ROBIN_EN
      for (int i = 0; i < N; i++) if (rem[i] == 0) rem[i] = 1;
      drive_inputs();
`endif
      tick();
    end
    chk("r033_count", hs_port.size() >= n033, 1);
    for (int k = 0; k < n033; k++) chk($sformatf("r033_sel%0d", k), hs_port[k], e033[k]);

    // Reset in the middle of a port-3 packet.
    clear_sources();
    hs_port.delete();
    rem[3]    = 4;
    out_ready = 1'b1;
    drive_inputs();
    run_until("r034_timeout", 2, 10);
    rst       = 1'b1;
    rem[3]    = 0;
    rem[0]    = 2;
    out_ready = 1'b0;
    drive_inputs();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    drive_inputs();
    #1;
    chk("r034_sel",   32'(out_sel),  32'd0);
    chk("r034_ready", 32'(in_ready), 32'b0001);
    tick();
    run_until("r034_drain", 1, 10);

    // Randomized traffic with random gaps and backpressure.
    do_reset();
    auto_new = 1;
    repeat (600) tick();
    auto_new = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
